// File: rtl/game_end_of_round_timer_pkg.sv
// Shared defaults, state encoding and BCD helper for the end-of-round timer.
package game_end_of_round_timer_pkg;

  localparam int PRESCALE_DEFAULT    = 2_500_000;
  localparam int TIMER_TICKS_DEFAULT = 40;
  localparam int BLINK_TICKS_DEFAULT = 5;

  localparam logic [7:0] BCD_MAX = 8'h99;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RUNNING = 1'b1
  } state_t;

  // Two-digit BCD increment that holds at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == BCD_MAX) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/game_end_of_round_timer_bcd_counter.sv
// Two-digit saturating BCD tally; clear wins over increment.
module game_bcd_counter_2d
  import game_end_of_round_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      value <= 8'h00;
    else if (clear) value <= 8'h00;
    else if (inc)   value <= bcd_inc(value);
  end

endmodule

// File: rtl/game_end_of_round_timer.sv
// End-of-round pause timer: holds the pause, blinks the display, latches and
// tallies the round result at expiry.
module game_end_of_round_timer
  import game_end_of_round_timer_pkg::*;
#(
  parameter int PRESCALE    = PRESCALE_DEFAULT,
  parameter int TIMER_TICKS = TIMER_TICKS_DEFAULT,
  parameter int BLINK_TICKS = BLINK_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       end_of_game_timer_start,
  input  logic       game_won,
  input  logic       score_clear,
  output logic       end_of_game_timer_running,
  output logic       blink,
  output logic       round_done,
  output logic       last_result_valid,
  output logic       last_result_won,
  output logic [7:0] wins_bcd,
  output logic [7:0] losses_bcd
);

  localparam int PW = $clog2(PRESCALE);
  localparam int TW = $clog2(TIMER_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TICKS_LOAD = TW'(TIMER_TICKS);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_TICKS);

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [TW-1:0] ticks_left;
  logic [BW-1:0] blink_cnt;
  logic          tick;
  logic          expire;
  logic          start;

  assign start  = end_of_game_timer_start;
  assign tick   = (state == S_RUNNING) && (presc == PRESC_LAST);
  assign expire = tick && (ticks_left == TW'(1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_RUNNING;
      S_RUNNING: if (expire && !start) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  assign end_of_game_timer_running = (state == S_RUNNING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc             <= '0;
      ticks_left        <= '0;
      blink_cnt         <= '0;
      blink             <= 1'b0;
      round_done        <= 1'b0;
      last_result_valid <= 1'b0;
      last_result_won   <= 1'b0;
    end else begin
      round_done <= expire;
      if (expire) begin
        last_result_valid <= 1'b1;
        last_result_won   <= game_won;
      end
      // A start always reloads the pause, even on the expiry edge.
      if (start) begin
        presc      <= '0;
        ticks_left <= TICKS_LOAD;
        blink_cnt  <= BLINK_LOAD;
        blink      <= 1'b1;
      end else if (state == S_RUNNING) begin
        if (tick) begin
          presc <= '0;
          if (expire) begin
            ticks_left <= '0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
          end else begin
            ticks_left <= ticks_left - TW'(1);
            if (blink_cnt == BW'(1)) begin
              blink     <= ~blink;
              blink_cnt <= BLINK_LOAD;
            end else begin
              blink_cnt <= blink_cnt - BW'(1);
            end
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  game_bcd_counter_2d u_wins (
    .clk   (clk),
    .reset (reset),
    .clear (score_clear),
    .inc   (expire && game_won),
    .value (wins_bcd)
  );

  game_bcd_counter_2d u_losses (
    .clk   (clk),
    .reset (reset),
    .clear (score_clear),
    .inc   (expire && !game_won),
    .value (losses_bcd)
  );

endmodule

// File: tb/tb_game_end_of_round_timer.sv
// Directed bench for game_end_of_round_timer with PRESCALE=4, TIMER_TICKS=3, BLINK_TICKS=1.
module tb_game_end_of_round_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       game_won;
  logic       score_clear;
  logic       running;
  logic       blink;
  logic       round_done;
  logic       last_result_valid;
  logic       last_result_won;
  logic [7:0] wins_bcd;
  logic [7:0] losses_bcd;

  int errors = 0;
  int checks = 0;

  game_end_of_round_timer #(
    .PRESCALE    (4),
    .TIMER_TICKS (3),
    .BLINK_TICKS (1)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .end_of_game_timer_start   (start),
    .game_won                  (game_won),
    .score_clear               (score_clear),
    .end_of_game_timer_running (running),
    .blink                     (blink),
    .round_done                (round_done),
    .last_result_valid         (last_result_valid),
    .last_result_won           (last_result_won),
    .wins_bcd                  (wins_bcd),
    .losses_bcd                (losses_bcd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts running cycles from the current one until running falls (bounded).
  // Blink is compared against a fresh-pause pattern: 4 cycles per half period.
  task automatic wait_idle(output int cnt, output int blink_bad, output int rd_seen);
    cnt = 0;
    blink_bad = 0;
    rd_seen = 0;
    while (running === 1'b1 && cnt < 200) begin
      if (blink !== (((cnt / 4) % 2) == 0)) blink_bad++;
      if (round_done === 1'b1) rd_seen++;
      cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    game_won = 1'b0;
    score_clear = 1'b0;
    repeat (3) step();
    checks++;
    if ({running, blink, round_done, last_result_valid, last_result_won, wins_bcd, losses_bcd} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {running, blink, round_done, last_result_valid, last_result_won, wins_bcd, losses_bcd});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_first_win();
    int cnt, bb, rd;
    game_won = 1'b1;
    start_round();
    checks++;
    if (running !== 1'b1 || blink !== 1'b1) begin
      errors++;
      $display("FAIL start_response: running=%b blink=%b want 1 1", running, blink);
    end
    wait_idle(cnt, bb, rd);
    checks++;
    if (cnt !== 12) begin
      errors++;
      $display("FAIL pause_length: got %0d want 12", cnt);
    end
    checks++;
    if (bb !== 0) begin
      errors++;
      $display("FAIL blink_pattern: %0d bad cycles want 0", bb);
    end
    checks++;
    if (round_done !== 1'b1 || blink !== 1'b0) begin
      errors++;
      $display("FAIL expiry_pulse: round_done=%b blink=%b want 1 0", round_done, blink);
    end
    checks++;
    if (wins_bcd !== 8'h01 || losses_bcd !== 8'h00 || last_result_won !== 1'b1 || last_result_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_win_score: wins=%h losses=%h won=%b valid=%b want 01 00 1 1",
               wins_bcd, losses_bcd, last_result_won, last_result_valid);
    end
    step();
    checks++;
    if (round_done !== 1'b0) begin
      errors++;
      $display("FAIL round_done_width: got %b want 0", round_done);
    end
  endtask

  task automatic test_loss();
    int cnt, bb, rd;
    game_won = 1'b1;
    start_round();
    repeat (6) step();
    game_won = 1'b0;
    wait_idle(cnt, bb, rd);
    checks++;
    if (losses_bcd !== 8'h01 || wins_bcd !== 8'h01 || last_result_won !== 1'b0) begin
      errors++;
      $display("FAIL loss_score: losses=%h wins=%h won=%b want 01 01 0",
               losses_bcd, wins_bcd, last_result_won);
    end
  endtask

  task automatic test_retrigger();
    int cnt, bb, rd;
    game_won = 1'b1;
    start_round();
    repeat (4) step();
    start_round();
    wait_idle(cnt, bb, rd);
    checks++;
    if (cnt !== 12 || rd !== 0) begin
      errors++;
      $display("FAIL retrigger_length: got %0d cycles %0d early done want 12 0", cnt, rd);
    end
    checks++;
    if (wins_bcd !== 8'h02 || losses_bcd !== 8'h01) begin
      errors++;
      $display("FAIL retrigger_score: wins=%h losses=%h want 02 01", wins_bcd, losses_bcd);
    end
  endtask

  task automatic test_saturation();
    int cnt, bb, rd;
    score_clear = 1'b1;
    step();
    score_clear = 1'b0;
    checks++;
    if (wins_bcd !== 8'h00 || losses_bcd !== 8'h00) begin
      errors++;
      $display("FAIL score_clear: wins=%h losses=%h want 00 00", wins_bcd, losses_bcd);
    end
    game_won = 1'b1;
    for (int i = 0; i < 9; i++) begin
      start_round();
      wait_idle(cnt, bb, rd);
    end
    checks++;
    if (wins_bcd !== 8'h09) begin
      errors++;
      $display("FAIL nine_wins: got %h want 09", wins_bcd);
    end
    start_round();
    wait_idle(cnt, bb, rd);
    checks++;
    if (wins_bcd !== 8'h10) begin
      errors++;
      $display("FAIL units_carry: got %h want 10", wins_bcd);
    end
    for (int i = 0; i < 89; i++) begin
      start_round();
      wait_idle(cnt, bb, rd);
    end
    checks++;
    if (wins_bcd !== 8'h99) begin
      errors++;
      $display("FAIL reach_99: got %h want 99", wins_bcd);
    end
    start_round();
    wait_idle(cnt, bb, rd);
    checks++;
    if (wins_bcd !== 8'h99 || losses_bcd !== 8'h00) begin
      errors++;
      $display("FAIL saturate_99: wins=%h losses=%h want 99 00", wins_bcd, losses_bcd);
    end
  endtask

  task automatic test_clear_on_expiry();
    game_won = 1'b1;
    start_round();
    repeat (11) step();
    score_clear = 1'b1;
    step();
    score_clear = 1'b0;
    checks++;
    if (running !== 1'b0 || round_done !== 1'b1 || wins_bcd !== 8'h00 || last_result_won !== 1'b1) begin
      errors++;
      $display("FAIL clear_on_expiry: running=%b done=%b wins=%h won=%b want 0 1 00 1",
               running, round_done, wins_bcd, last_result_won);
    end
    step();
  endtask

  task automatic test_start_on_expiry();
    int cnt, bb, rd;
    game_won = 1'b1;
    start_round();
    repeat (11) step();
    start_round();
    checks++;
    if (running !== 1'b1 || wins_bcd !== 8'h01 || blink !== 1'b1) begin
      errors++;
      $display("FAIL start_on_expiry: running=%b wins=%h blink=%b want 1 01 1", running, wins_bcd, blink);
    end
    wait_idle(cnt, bb, rd);
    checks++;
    if (cnt !== 12 || wins_bcd !== 8'h02) begin
      errors++;
      $display("FAIL fresh_pause: cycles=%0d wins=%h want 12 02", cnt, wins_bcd);
    end
  endtask

  task automatic test_reset_mid_pause();
    int cnt, bb, rd;
    int rd_after;
    game_won = 1'b1;
    start_round();
    repeat (5) step();
    reset = 1'b1;
    #1;
    checks++;
    if (running !== 1'b0 || round_done !== 1'b0 || wins_bcd !== 8'h00 || losses_bcd !== 8'h00
        || last_result_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: running=%b done=%b wins=%h losses=%h valid=%b want 0 0 00 00 0",
               running, round_done, wins_bcd, losses_bcd, last_result_valid);
    end
    step();
    reset = 1'b0;
    rd_after = 0;
    for (int i = 0; i < 15; i++) begin
      if (round_done !== 1'b0 || running !== 1'b0) rd_after++;
      step();
    end
    checks++;
    if (rd_after !== 0 || wins_bcd !== 8'h00) begin
      errors++;
      $display("FAIL no_done_after_reset: %0d active cycles wins=%h want 0 00", rd_after, wins_bcd);
    end
    game_won = 1'b0;
    start_round();
    wait_idle(cnt, bb, rd);
    checks++;
    if (cnt !== 12 || losses_bcd !== 8'h01 || last_result_valid !== 1'b1 || last_result_won !== 1'b0) begin
      errors++;
      $display("FAIL restart_after_reset: cycles=%0d losses=%h valid=%b won=%b want 12 01 1 0",
               cnt, losses_bcd, last_result_valid, last_result_won);
    end
  endtask

  initial begin
    test_reset();
    test_first_win();
    test_loss();
    test_retrigger();
    test_saturation();
    test_clear_on_expiry();
    test_start_on_expiry();
    test_reset_mid_pause();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
